param_down_counter: RTL and testbench
=====================================

# param_down_counter

Parameterized loadable down-counter/timer with terminal-count pulse and optional auto-reload. It is the count-down companion to the team's parameterized up-counter. It serves as a programmable interval timer or timeout generator: software or an FSM loads a count, and downstream logic consumes the one-cycle `tc` pulse or the `done` level. Count width is derived from `MOD`, so the same instance style scales from tiny timeouts to wide intervals.

## Interface
- `MOD`, default 65536: modulus. Legal count values are 0..MOD-1. MOD ≥ 2.
- `W` (localparam, not overridable) = $clog2(MOD): width of `q` and `load_val`.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous abort: return to IDLE.
- `load`  in  1  capture `load_val`, enter RUN.
- `load_val`  in  W  start and reload value; values > MOD-1 are clamped to MOD-1.
- `auto_reload`  in  1  sampled at `load`; 1 = periodic, 0 = one-shot.
- `en`  in  1  count enable (decrement qualifier).
- `q`  out  W  current count.
- `tc`  out  1  terminal-count pulse, registered, exactly one cycle wide per expiry.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE (one-shot expired).

## Operation
- Three-state FSM:
  - IDLE: q=0, busy=0, done=0.
  - RUN: busy=1.
  - DONE: q=0, done=1.
- Per-edge priority: rst_ (async) > clr > load > en.
- `clr` from any state goes to IDLE: q←0, tc←0. The reload register and mode are cleared.
- `load` from any state:
  - reload_reg ← clamp(load_val); q ← clamp(load_val).
  - mode ← auto_reload.
  - state ← RUN; tc ← 0.
  - A load in RUN restarts the count and suppresses any pending expiry.
- RUN with en=1 and q≠0: q ← q−1, tc ← 0.
- RUN with en=1 and q==0 (expiry): tc ← 1.
  - mode=1: q ← reload_reg, stay in RUN.
  - mode=0: state ← DONE, q stays 0.
- RUN with en=0: q holds, tc ← 0. `en` gaps stretch the interval and never lose counts.
- IDLE/DONE: `en` is ignored and tc ← 0.
- Load of 0 is legal: the first enabled cycle after the load expires.
- Interval from load to tc is value+1 enabled cycles. With auto-reload the period is reload+1 enabled cycles.
- Arithmetic is unsigned, W bits. q never underflows, because expiry is taken at 0 instead of decrementing.

## Timing
- Reset values: q=0, tc=0, busy=0, done=0, state IDLE, reload_reg=0, mode=0.
- All outputs are registered, with no combinational input-to-output paths.
- Load sampled at edge k: q=clamp(load_val) and busy=1 are visible after edge k.
- Expiry at edge j, with q==0 and en=1 before the edge:
  - tc is high from edge j to edge j+1.
  - In one-shot mode, done=1 and busy=0 from edge j.
- Back-to-back expiries (reload 0, en held high): tc stays high continuously, one pulse per cycle.
- Asynchronous reset mid-RUN clears everything immediately; no tc is produced.

## Structure
- Shared package holds:
  - the state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the width/clamp helper used here and by the up-counter.
- No sub-module. The clamp, FSM and datapath stay in this block.

## Test plan
- MOD=10; load 3, auto_reload=0, en=1 held → q: 3,2,1,0. tc high for one cycle on the edge after q==0. Then done=1, busy=0, q=0, and no further tc.
- MOD=10; load 2, auto_reload=1, en=1 held → q cycles 2,1,0,2,1,0… and tc fires every 3 cycles. Load 0 with auto-reload → tc high every cycle.
- MOD=10; load_val=15 → q=9 after the load edge. MOD=16, load_val=15 → q=15 with no clamp.
- en toggled 1,0,1,0 after load 2 → q decrements only on enabled edges. tc occurs after exactly 3 enabled edges.
- clr and load asserted in the same cycle during RUN with q=5 → IDLE, q=0, no tc. Load during RUN at q=1 → restart, and no tc from the old count.
- rst_ dropped asynchronously mid-RUN at q=4 → q=0, busy=0, done=0, tc=0 immediately. After release, load 1 → tc after 2 enabled edges.

Source files
------------

// File: rtl/param_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// param_down_counter_pkg
// Shared definitions for the parameterized counter family (down-counter and
// its up-counting companion).
//   state_e      : FSM encoding of the down-counter (IDLE / RUN / DONE).
//   cnt_width()  : register width needed to hold counts 0..modulus-1.
//   clamp_to_max : saturates a requested count to the largest legal value.
// -----------------------------------------------------------------------------
package param_down_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // $clog2(2) is 1, and moduli below 2 are not legal, so a 1-bit floor
    // only protects against a degenerate zero-width vector.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus < 3) ? 1 : $clog2(modulus);
    endfunction

    function automatic int unsigned clamp_to_max(input int unsigned value,
                                                 input int unsigned max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/param_down_counter.sv
// -----------------------------------------------------------------------------
// param_down_counter
// Loadable down-counter / interval timer with a registered one-cycle
// terminal-count pulse and optional periodic auto-reload.
//
// Parameters: the modulus (>= 2) sets the legal counts 0..modulus-1, and the
// count width W is derived from it (not overridable).
// Ports
//   clk          clock, rising edge
//   rst_         asynchronous active-low reset
//   clr          synchronous abort back to IDLE (clears reload value and mode)
//   load         capture load_val (clamped to the largest legal count) and start
//   load_val     start / reload value
//   auto_reload  sampled with load: 1 = periodic, 0 = one-shot
//   en           decrement qualifier while running
//   q            current count
//   tc           terminal-count pulse, one cycle per expiry
//   busy         high while running
//   done         high after a one-shot expiry until the next load/clr
//
// Edge priority: rst_ > clr > load > en. All outputs come straight from
// flops, so there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module param_down_counter
    import param_down_counter_pkg::*;
#(
    parameter  int unsigned MOD = 65536,
    localparam int unsigned W   = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         auto_reload,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    state_e         state_q;
    logic [W-1:0]   count_q;
    logic [W-1:0]   reload_q;
    logic           mode_q;
    logic           tc_q;
    logic           busy_q;
    logic           done_q;

    // When MOD is a power of two every W-bit value is legal and the clamp
    // reduces to a pass-through.
    logic [W-1:0]   load_val_clamped;
    assign load_val_clamped = W'(clamp_to_max(32'(load_val), MOD - 1));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (clr) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (load) begin
            // A load while running restarts the interval; clearing tc here
            // is what suppresses an expiry that was about to happen.
            state_q  <= ST_RUN;
            count_q  <= load_val_clamped;
            reload_q <= load_val_clamped;
            mode_q   <= auto_reload;
            tc_q     <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!en) begin
                        tc_q <= 1'b0;
                    end else if (count_q != '0) begin
                        count_q <= count_q - W'(1);
                        tc_q    <= 1'b0;
                    end else begin
                        // Expiry is taken at zero instead of decrementing,
                        // so the count never wraps.
                        tc_q <= 1'b1;
                        if (mode_q) begin
                            count_q <= reload_q;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    tc_q <= 1'b0;
                end
                default: begin
                    tc_q <= 1'b0;
                end
            endcase
        end
    end

    assign q    = count_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_param_down_counter.sv
// -----------------------------------------------------------------------------
// tb_param_down_counter
// Directed bench for param_down_counter. Two instances share all inputs:
// u_dut10 (MOD=10, clamps values above 9) and u_dut16 (MOD=16, no clamp).
// Each stimulus step drives inputs on a falling edge and queues the outputs
// expected after the following rising edge; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_param_down_counter;

    logic       clk = 1'b0;
    logic       rst_;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       auto_reload;
    logic       en;

    logic [3:0] q10, q16;
    logic       tc10, tc16, busy10, busy16, done10, done16;

    always #5 clk = ~clk;

    param_down_counter #(.MOD(10)) u_dut10 (
        .clk(clk), .rst_(rst_), .clr(clr), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .en(en),
        .q(q10), .tc(tc10), .busy(busy10), .done(done10)
    );

    param_down_counter #(.MOD(16)) u_dut16 (
        .clk(clk), .rst_(rst_), .clr(clr), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .en(en),
        .q(q16), .tc(tc16), .busy(busy16), .done(done16)
    );

    typedef struct {
        int    q;
        int    q16;
        logic  tc;
        logic  busy;
        logic  done;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk({e.nm, ".q10"},    int'(q10),    e.q);
        chk({e.nm, ".tc10"},   int'(tc10),   int'(e.tc));
        chk({e.nm, ".busy10"}, int'(busy10), int'(e.busy));
        chk({e.nm, ".done10"}, int'(done10), int'(e.done));
        chk({e.nm, ".q16"},    int'(q16),    e.q16);
        chk({e.nm, ".tc16"},   int'(tc16),   int'(e.tc));
        chk({e.nm, ".busy16"}, int'(busy16), int'(e.busy));
        chk({e.nm, ".done16"}, int'(done16), int'(e.done));
    endtask

    // Apply inputs for one cycle and queue what both DUTs must show after
    // the next rising edge. exp_q16 < 0 means "same as the MOD=10 count".
    task automatic step(input logic c, input logic l, input int lv,
                        input logic ar, input logic e,
                        input int exp_q, input int exp_q16,
                        input logic exp_tc, input logic exp_busy,
                        input logic exp_done, input string nm);
        exp_t x;
        @(negedge clk);
        clr         = c;
        load        = l;
        load_val    = 4'(lv);
        auto_reload = ar;
        en          = e;
        x.q    = exp_q;
        x.q16  = (exp_q16 < 0) ? exp_q : exp_q16;
        x.tc   = exp_tc;
        x.busy = exp_busy;
        x.done = exp_done;
        x.nm   = nm;
        sb.push_back(x);
    endtask

    // Monitor: compare once per rising edge whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_all(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t r;
        rst_ = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        auto_reload = 1'b0; en = 1'b0;

        //   clr load lv ar en    q  q16 tc busy done
        step(0, 0, 0, 0, 0,       0, -1, 0, 0, 0, "reset");
        @(negedge clk);
        rst_ = 1'b1;
        step(0, 0, 0, 0, 1,       0, -1, 0, 0, 0, "idle_en_ignored");

        // One-shot, load 3: 3,2,1,0 then tc on the next enabled edge.
        step(0, 1, 3, 0, 1,       3, -1, 0, 1, 0, "os_load3");
        step(0, 0, 0, 0, 1,       2, -1, 0, 1, 0, "os_q2");
        step(0, 0, 0, 0, 1,       1, -1, 0, 1, 0, "os_q1");
        step(0, 0, 0, 0, 1,       0, -1, 0, 1, 0, "os_q0");
        step(0, 0, 0, 0, 1,       0, -1, 1, 0, 1, "os_expire");
        step(0, 0, 0, 0, 1,       0, -1, 0, 0, 1, "os_done1");
        step(0, 0, 0, 0, 1,       0, -1, 0, 0, 1, "os_done2");

        // Auto-reload, load 2: tc every 3 enabled cycles.
        step(0, 1, 2, 1, 1,       2, -1, 0, 1, 0, "ar_load2");
        step(0, 0, 0, 0, 1,       1, -1, 0, 1, 0, "ar_q1");
        step(0, 0, 0, 0, 1,       0, -1, 0, 1, 0, "ar_q0");
        step(0, 0, 0, 0, 1,       2, -1, 1, 1, 0, "ar_tc1");
        step(0, 0, 0, 0, 1,       1, -1, 0, 1, 0, "ar_q1b");
        step(0, 0, 0, 0, 1,       0, -1, 0, 1, 0, "ar_q0b");
        step(0, 0, 0, 0, 1,       2, -1, 1, 1, 0, "ar_tc2");

        // Auto-reload of 0: tc held high, one pulse per cycle.
        step(0, 1, 0, 1, 1,       0, -1, 0, 1, 0, "ar0_load");
        step(0, 0, 0, 0, 1,       0, -1, 1, 1, 0, "ar0_tc1");
        step(0, 0, 0, 0, 1,       0, -1, 1, 1, 0, "ar0_tc2");
        step(0, 0, 0, 0, 1,       0, -1, 1, 1, 0, "ar0_tc3");
        step(0, 0, 0, 0, 0,       0, -1, 0, 1, 0, "ar0_en_off");

        // Clamp: 15 becomes 9 for MOD=10, stays 15 for MOD=16.
        step(1, 0, 0, 0, 0,       0, -1, 0, 0, 0, "clr_before_clamp");
        step(0, 1, 15, 0, 0,      9, 15, 0, 1, 0, "clamp_load15");
        step(0, 0, 0, 0, 0,       9, 15, 0, 1, 0, "clamp_hold");
        step(1, 0, 0, 0, 0,       0, -1, 0, 0, 0, "clamp_clr");

        // en gaps: load 2, en 1,0,1,0,1 -> tc after the third enabled edge.
        step(0, 1, 2, 0, 0,       2, -1, 0, 1, 0, "gap_load2");
        step(0, 0, 0, 0, 1,       1, -1, 0, 1, 0, "gap_en1");
        step(0, 0, 0, 0, 0,       1, -1, 0, 1, 0, "gap_en0");
        step(0, 0, 0, 0, 1,       0, -1, 0, 1, 0, "gap_en1b");
        step(0, 0, 0, 0, 0,       0, -1, 0, 1, 0, "gap_en0b");
        step(0, 0, 0, 0, 1,       0, -1, 1, 0, 1, "gap_expire");

        // clr beats load in the same cycle.
        step(0, 1, 5, 0, 0,       5, -1, 0, 1, 0, "cl_load5");
        step(1, 1, 7, 0, 1,       0, -1, 0, 0, 0, "cl_clr_and_load");
        step(0, 0, 0, 0, 1,       0, -1, 0, 0, 0, "cl_idle");

        // Reload at q=1 restarts the count; the old expiry never appears.
        step(0, 1, 1, 0, 0,       1, -1, 0, 1, 0, "rs_load1");
        step(0, 1, 3, 0, 1,       3, -1, 0, 1, 0, "rs_reload3");
        step(0, 0, 0, 0, 1,       2, -1, 0, 1, 0, "rs_q2");
        step(0, 0, 0, 0, 1,       1, -1, 0, 1, 0, "rs_q1");
        step(0, 0, 0, 0, 1,       0, -1, 0, 1, 0, "rs_q0");
        step(0, 0, 0, 0, 1,       0, -1, 1, 0, 1, "rs_expire");

        // Asynchronous reset in the middle of a cycle at q=4.
        step(0, 1, 6, 1, 0,       6, -1, 0, 1, 0, "ar_rst_load6");
        step(0, 0, 0, 0, 1,       5, -1, 0, 1, 0, "ar_rst_q5");
        step(0, 0, 0, 0, 1,       4, -1, 0, 1, 0, "ar_rst_q4");
        @(posedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        r.q = 0; r.q16 = 0; r.tc = 1'b0; r.busy = 1'b0; r.done = 1'b0;
        r.nm = "async_rst";
        check_all(r);
        @(negedge clk);
        rst_ = 1'b1;
        step(0, 0, 0, 0, 1,       0, -1, 0, 0, 0, "post_rst_idle");

        // After reset release, load 1 expires after 2 enabled edges.
        step(0, 1, 1, 0, 1,       1, -1, 0, 1, 0, "pr_load1");
        step(0, 0, 0, 0, 1,       0, -1, 0, 1, 0, "pr_q0");
        step(0, 0, 0, 0, 1,       0, -1, 1, 0, 1, "pr_expire");
        step(0, 0, 0, 0, 1,       0, -1, 0, 0, 1, "pr_done");

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
